divider_frac_arb: RTL
=====================

# divider_frac_arb

Round-robin arbiter and sequencer that shares one `divider_frac` instance among `NUM_REQ` requesters in the morphing-wing peripheral. Each requester hands over a 12-bit dividend/divisor pair through a valid/ready handshake. The arbiter drives the divider for a fixed latency, captures the 24-bit 12.12 fixed-point quotient, and returns it to the granted requester through a per-requester valid/ready response. The arbiter never relies on the divider's output-valid flag; completion is timed by an internal counter.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2..8.
- `DIV_LATENCY`, 1: edges from divider input sampling to result valid; must be ≥1.

Ports, clock and reset first:
- `aclk`  in  1  single clock; all logic is rising-edge.
- `areset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  one-hot accept pulse.
- `req_dividend`  in  12*NUM_REQ  packed dividends; requester i uses bits [12i+11:12i].
- `req_divisor`  in  12*NUM_REQ  packed divisors, same packing.
- `rsp_valid`  out  NUM_REQ  one-hot response valid.
- `rsp_ready`  in  NUM_REQ  per-requester response ready.
- `rsp_data`  out  24  quotient, integer part [23:12], fraction [11:0].
- `div_dividend`  out  12  to divider dividend.
- `div_divisor`  out  12  to divider divisor.
- `div_valid`  out  1  drives both divider tvalid inputs.
- `div_dout`  in  24  divider result.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: `req_ready` = one-hot grant, computed combinationally from `req_valid` by round-robin starting at `ptr`. When any request is valid: latch the winner's operands and index `gnt`, then go to BUSY.
  - BUSY: `div_valid`=1; `div_dividend`/`div_divisor` are held at the latched operands. Counter `cnt` runs 0..DIV_LATENCY. At the edge ending `cnt==DIV_LATENCY`, capture `div_dout` into `rsp_data` and go to RESP.
  - RESP: `rsp_valid[gnt]`=1 and `div_valid`=0. On `rsp_ready[gnt]`, go to IDLE with `ptr`←(gnt+1) mod NUM_REQ.
- Round-robin pointer:
  - Priority order is `ptr`, `ptr`+1, …, wrapping.
  - `ptr` advances only on response completion.
  - A requester holding `req_valid` continuously is served at most once per full rotation when others are pending.
- `rsp_ready` of non-granted requesters is ignored.
- `rsp_data` and `rsp_valid` hold stable until the handshake completes.
- `req_valid` dropping after acceptance has no effect.
- Divider operands are held constant throughout BUSY.
- Reset values: all outputs 0, `rsp_data`=24'h000000, state IDLE, `ptr`=0, `cnt`=0.
- Reset mid-operation aborts immediately. An in-flight result is discarded and no response is issued. The divider sees `div_valid`=0 from reset assertion onward.

## Timing
- Request accepted at edge E0: `rsp_valid` rises after edge E0+DIV_LATENCY+1.
- Response handshake at edge E1: the next `req_ready` can occur in the cycle after E1, so the minimum op period is DIV_LATENCY+3 cycles.
- Response handshake and new requests in the same cycle: the new request waits one cycle, because IDLE is entered first.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.

## Configuration
- `DIVIDER_FRAC_ZERO_BYPASS_EN`:
  - Defined: a divisor of 0 is detected in IDLE at acceptance. The FSM goes directly to RESP with `rsp_data`=24'hFFFFFF; BUSY is skipped and `div_valid` stays 0. `rsp_valid` rises after E0+1.
  - Undefined: zero divisors are sent to the divider like any other request, and its output is returned unchanged.

## Structure
- Package `divider_frac_pkg`:
  - `DIV_W`=12, `Q_W`=24, `Q_ALL_ONES`=24'hFFFFFF.
  - state enum `{IDLE, BUSY, RESP}`.
- Sub-module `rr_arbiter_n`: combinational round-robin one-hot picker with inputs `req` and `ptr` and output `gnt` one-hot. It carries no state; `ptr` is owned by `divider_frac_arb`.
- `divider_frac` is instantiated by the parent and is not inside this block.

## Test plan
- Requester 0 sends 7/2 with a divider model of DIV_LATENCY=1 → `req_ready[0]` pulses once; `div_valid` is high for exactly 2 cycles; `rsp_valid[0]` after E0+2 with `rsp_data`=24'h003800.
- Requester 2 sends 1/3 → `rsp_data`=24'h000555, and only `rsp_valid[2]` is asserted.
- All four requesters hold `req_valid`=1 with `rsp_ready` tied 1 → grant order 0,1,2,3,0,1, and each grant arrives DIV_LATENCY+3 cycles apart.
- `rsp_ready` is held low for 10 cycles in RESP → `rsp_valid` and `rsp_data` are stable, `div_valid`=0, and no `req_ready` pulses; completion occurs on the first cycle `rsp_ready` goes high.
- Divisor 0 with dividend 5:
  - With the macro: response 24'hFFFFFF after E0+1 and `div_valid` never asserts.
  - Without the macro: the divider model's output is returned after E0+DIV_LATENCY+1.
- `areset` is pulsed during BUSY → outputs are 0 immediately, no `rsp_valid` is issued, and the next grant goes to requester 0.

Source files
------------

// File: rtl/divider_frac_pkg.sv
// Shared widths, constants and FSM state type for the fractional-divider arbiter.
package divider_frac_pkg;

  localparam int unsigned DIV_W = 12;
  localparam int unsigned Q_W   = 24;

  localparam logic [Q_W-1:0] Q_ALL_ONES = 24'hFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

endpackage

// File: rtl/divider_frac_arb_if.sv
// Requester-side bundle: per-requester request and response valid/ready handshakes.
interface divider_frac_arb_if #(
  parameter int unsigned NUM_REQ = 4
);
  import divider_frac_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [DIV_W*NUM_REQ-1:0] req_dividend;
  logic [DIV_W*NUM_REQ-1:0] req_divisor;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [Q_W-1:0]           rsp_data;

  // Requester side
  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/divider_frac_arb_rr.sv
// Stateless round-robin one-hot picker; priority starts at ptr and wraps upward.
module rr_arbiter_n #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    gnt
);

  logic found;

  // Scan distances 0..N-1 from ptr; the first requesting slot wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (32'(ptr) + k) % N)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/divider_frac_arb.sv
// Shares one fractional divider among NUM_REQ requesters with round-robin arbitration.
// Completion is timed by an internal counter, never by the divider's valid flag.
// Optional feature: define DIVIDER_FRAC_ZERO_BYPASS_EN to answer zero divisors with
// all-ones directly from IDLE without using the divider.
module divider_frac_arb
  import divider_frac_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DIV_LATENCY = 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  divider_frac_arb_if.slave    bus,
  output logic [DIV_W-1:0]     div_dividend,
  output logic [DIV_W-1:0]     div_divisor,
  output logic                 div_valid,
  input  logic [Q_W-1:0]       div_dout,
  output logic                 busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(DIV_LATENCY + 1);

  state_e               state_q;
  logic [PtrW-1:0]      ptr_q;
  logic [PtrW-1:0]      gnt_q;
  logic [CntW-1:0]      cnt_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [Q_W-1:0]       rsp_data_q;
  logic [DIV_W-1:0]     dividend_q;
  logic [DIV_W-1:0]     divisor_q;
  logic                 div_valid_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [PtrW-1:0]      gnt_idx;
  logic [DIV_W-1:0]     sel_dividend;
  logic [DIV_W-1:0]     sel_divisor;
  logic [PtrW-1:0]      ptr_nxt;
  logic                 zero_bypass;

  rr_arbiter_n #(
    .N    (NUM_REQ),
    .PtrW (PtrW)
  ) u_rr_arbiter (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Convert the one-hot grant to an index and mux out the winner's operands.
  always_comb begin
    gnt_idx      = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        gnt_idx      = i[PtrW-1:0];
        sel_dividend = bus.req_dividend[DIV_W*i +: DIV_W];
        sel_divisor  = bus.req_divisor[DIV_W*i +: DIV_W];
      end
    end
  end

`ifdef DIVIDER_FRAC_ZERO_BYPASS_EN
  assign zero_bypass = (sel_divisor == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  assign ptr_nxt = (gnt_q == PtrW'(NUM_REQ - 1)) ? '0 : gnt_q + PtrW'(1);

  // Accept pulses only in IDLE; held off while reset is asserted so outputs read 0.
  assign bus.req_ready = (state_q == IDLE && !areset) ? arb_gnt : '0;

  // Main sequencer: accept, drive divider for DIV_LATENCY+1 cycles, hold response.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      div_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|bus.req_valid) begin
            gnt_q      <= gnt_idx;
            dividend_q <= sel_dividend;
            divisor_q  <= sel_divisor;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            if (zero_bypass) begin
              rsp_data_q  <= Q_ALL_ONES;
              rsp_valid_q <= arb_gnt;
              state_q     <= RESP;
            end else begin
              div_valid_q <= 1'b1;
              state_q     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q == CntW'(DIV_LATENCY)) begin
            rsp_data_q  <= div_dout;
            rsp_valid_q <= NUM_REQ'(1) << gnt_q;
            div_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready[gnt_q]) begin
            rsp_valid_q <= '0;
            ptr_q       <= ptr_nxt;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;
  assign div_valid     = div_valid_q;
  assign busy          = busy_q;

endmodule
